// File: rtl/dma_start_arbiter.sv
// dma_start_arbiter: synchronises NCH start requests, latches rising edges and grants one channel at a time round-robin until done or timeout
module dma_start_arbiter #(
  parameter int NCH = 4,
  parameter int SYNC = 2,
  parameter int TO_W = 8,
  parameter int TO_MAX = 200,
  localparam int CW = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] sta_rt,
  input  logic [NCH-1:0] enable,
  input  logic           done,
  output logic           start,
  output logic [CW-1:0]  ch_sel,
  output logic           busy,
  output logic [NCH-1:0] pending,
  output logic           timeout
);
  localparam int SW = SYNC * NCH;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sync_q, sync_d;
  logic [NCH-1:0] prev_q, prev_d, pend_q, pend_d, req, rise, clr;
  logic [CW-1:0] sel_q, sel_d, last_q, last_d, pick;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d, found;
  int idx;
  always_comb begin
    sync_d = SW'({sync_q, sta_rt});
    prev_d = sync_q[SW-1 -: NCH];
    rise = prev_d & ~prev_q & enable;
    req = pend_q & enable;
    pick = '0;
    found = 1'b0;
    idx = 0;
    for (int j = 1; j <= NCH; j++) begin
      idx = (int'(last_q) + j) % NCH;
      if (!found && req[CW'(idx)]) begin
        pick = CW'(idx);
        found = 1'b1;
      end
    end
    state_d = state_q;
    sel_d = sel_q;
    last_d = last_q;
    cnt_d = cnt_q;
    to_d = 1'b0;
    clr = '0;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        sel_d = pick;
        last_d = pick;
        clr[pick] = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (done) state_d = IDLE;
        else if (cnt_q == TO_W'(TO_MAX - 1)) begin
          state_d = IDLE;
          to_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // a new edge on the channel being granted survives the clear
    pend_d = (pend_q & enable & ~clr) | rise;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      sel_q <= '0;
      last_q <= CW'(NCH - 1);
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      sel_q <= sel_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  assign start = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign ch_sel = sel_q;
  assign pending = pend_q;
  assign timeout = to_q;
endmodule

// File: tb/tb_dma_start_arbiter.sv
// tb_dma_start_arbiter: directed and random stimulus checked against a sample-history reference model
module tb_dma_start_arbiter;
  localparam int NCH = 4;
  localparam int SYNC = 2;
  localparam int TO_MAX = 10;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NCH-1:0] sta_rt = '0;
  logic [NCH-1:0] enable = '1;
  logic done = 1'b0;
  logic start, busy, timeout;
  logic [1:0] ch_sel;
  logic [NCH-1:0] pending;
  int total = 0;
  int bad = 0;
  int n_start = 0;
  bit [NCH-1:0] hist[$];
  bit [NCH-1:0] m_pend;
  int mode, sel, last, waited;
  bit m_to;
  int log_q[$];
  dma_start_arbiter #(.NCH(NCH), .SYNC(SYNC), .TO_W(8), .TO_MAX(TO_MAX)) dut (
    .clk(clk), .reset(reset), .sta_rt(sta_rt), .enable(enable), .done(done),
    .start(start), .ch_sel(ch_sel), .busy(busy), .pending(pending), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic model();
    bit [NCH-1:0] rise, clr;
    int g, c;
    if (reset) begin
      hist.delete();
      for (int j = 0; j < SYNC + 2; j++) hist.push_back('0);
      m_pend = '0;
      mode = 0;
      sel = 0;
      last = NCH - 1;
      waited = 0;
      m_to = 0;
    end else begin
      hist.push_front(sta_rt);
      void'(hist.pop_back());
      rise = hist[SYNC] & ~hist[SYNC+1] & enable;
      clr = '0;
      m_to = 0;
      g = -1;
      if (mode == 0) begin
        for (int j = 1; j <= NCH; j++) begin
          c = (last + j) % NCH;
          if (g < 0 && m_pend[c] && enable[c]) g = c;
        end
        if (g >= 0) begin
          mode = 1;
          sel = g;
          last = g;
          clr[g] = 1'b1;
        end
      end else if (mode == 1) begin
        mode = 2;
        waited = 0;
      end else begin
        waited++;
        if (done) mode = 0;
        else if (waited == TO_MAX) begin
          mode = 0;
          m_to = 1;
        end
      end
      m_pend = (m_pend & enable & ~clr) | rise;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("start", start, mode == 1);
    chk("busy", busy, mode != 0);
    chk("ch_sel", ch_sel, sel);
    chk("pending", pending, m_pend);
    chk("timeout", timeout, m_to);
    if (start) n_start++;
  endtask
  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wait_start(output int ch);
    int n = 0;
    ch = -1;
    while (!start && n < 40) begin
      step();
      n++;
    end
    chk("wait_start", start, 1'b1);
    if (start) ch = ch_sel;
  endtask
  task automatic wait_to(output int n);
    n = 0;
    while (!timeout && n < 30) begin
      step();
      n++;
    end
  endtask
  task automatic serve(int dly, logic [NCH-1:0] exp_pend);
    int ch;
    wait_start(ch);
    log_q.push_back(ch);
    chk("serve_pend", pending, exp_pend);
    steps(dly);
    done = 1'b1;
    step();
    done = 1'b0;
  endtask
  initial begin
    int ch, n;
    int exp_order[3] = '{0, 1, 3};
    steps(2);
    reset = 1'b0;
    step();
    chk("rst_pend", pending, 4'b0000);
    sta_rt = 4'b0100;
    step();
    chk("lat_k", pending[2], 1'b0);
    step();
    chk("lat_k1", pending[2], 1'b0);
    step();
    chk("lat_k2", pending[2], 1'b1);
    chk("lat_nostart", start, 1'b0);
    step();
    chk("p1_start", start, 1'b1);
    chk("p1_ch", ch_sel, 2);
    step();
    sta_rt = '0;
    steps(2);
    chk("p1_busy", busy, 1'b1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("p1_busy_drop", busy, 1'b0);
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    sta_rt = 4'b1011;
    log_q.delete();
    serve(3, 4'b1010);
    serve(3, 4'b1000);
    serve(3, 4'b0000);
    chk("rr_count", log_q.size(), 3);
    for (int i = 0; i < 3 && i < log_q.size(); i++) chk("rr_order", log_q[i], exp_order[i]);
    sta_rt = '0;
    steps(3);
    done = 1'b1;
    sta_rt = 4'b0010;
    n_start = 0;
    steps(50);
    chk("level_once", n_start, 1);
    sta_rt = '0;
    steps(3);
    sta_rt = 4'b0010;
    steps(10);
    chk("level_again", n_start, 2);
    done = 1'b0;
    sta_rt = '0;
    steps(3);
    sta_rt = 4'b0011;
    wait_start(ch);
    chk("to_ch0", ch, 0);
    step();
    wait_to(n);
    chk("to_delay0", n, 10);
    wait_start(ch);
    chk("to_next_ch1", ch, 1);
    step();
    wait_to(n);
    chk("to_delay1", n, 10);
    sta_rt = '0;
    steps(2);
    sta_rt = 4'b0100;
    wait_start(ch);
    chk("dw_ch", ch, 2);
    step();
    steps(9);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("dw_no_to", timeout, 1'b0);
    chk("dw_idle", busy, 1'b0);
    step();
    sta_rt = '0;
    steps(2);
    sta_rt = 4'b1000;
    wait_start(ch);
    chk("rs_ch3", ch, 3);
    sta_rt = 4'b1110;
    steps(3);
    chk("rs_pend", pending, 4'b0110);
    chk("rs_busy", busy, 1'b1);
    reset = 1'b1;
    sta_rt = '0;
    step();
    chk("rs_start", start, 1'b0);
    chk("rs_chsel", ch_sel, 0);
    chk("rs_busy0", busy, 1'b0);
    chk("rs_pend0", pending, 4'b0000);
    chk("rs_to", timeout, 1'b0);
    reset = 1'b0;
    steps(2);
    sta_rt = 4'b1000;
    wait_start(ch);
    chk("rs_fresh", ch, 3);
    steps(2);
    done = 1'b1;
    step();
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NCH; b++) if ($urandom_range(3) == 0) sta_rt[b] = ~sta_rt[b];
      enable = ($urandom_range(15) == 0) ? NCH'($urandom) : '1;
      done = $urandom_range(7) == 0;
      reset = $urandom_range(299) == 0;
      step();
    end
    reset = 1'b0;
    done = 1'b0;
    steps(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_start_arbiter.md
Name: dma_start_arbiter

Overview:
Multi-channel successor to the single-flop start register. Synchronises NCH asynchronous start requests and converts each rising edge into a latched pending request. Grants one channel at a time to the DMA engine using round-robin, then holds the grant until the engine signals completion or a watchdog timeout expires. It sits between the processor/peripheral start sources and the DMA transfer controller.

Parameters:
NCH, 4, number of request channels (2..16)
SYNC, 2, synchroniser depth per channel in flops (>=1)
TO_W, 8, timeout counter width in bits
TO_MAX, 200, cycles in WAIT without done before timeout (1..2^TO_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
sta_rt  input  NCH  raw start requests, one bit per channel, asynchronous level
enable  input  NCH  per-channel enable, synchronous
done  input  1  transfer-complete strobe from DMA engine
start  output  1  one-cycle pulse launching a transfer on ch_sel
ch_sel  output  clog2(NCH)  granted channel index, valid from start through end of WAIT
busy  output  1  high while a grant is active (ISSUE or WAIT)
pending  output  NCH  latched, not-yet-granted requests
timeout  output  1  one-cycle pulse when WAIT expires without done

Behaviour:
- Reset values: start=0, ch_sel=0, busy=0, pending=0, timeout=0. Synchroniser and edge-history flops 0. State IDLE. Round-robin pointer: last-granted = NCH-1, so channel 0 has first priority. Timeout counter 0.
- Synchroniser: SYNC flop chain per channel. Rising edge = last stage & ~previous value.
- Edge latency: if sta_rt[i] is first sampled high at edge k, pending[i] reads 1 after edge k+SYNC.
- Levels do not retrigger. A held-high sta_rt produces exactly one request until it drops and rises again.
- Edges on channels with enable[i]=0 are ignored. Deasserting enable[i] clears pending[i] on the next edge. A channel already granted completes normally.
- FSM IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: if any pending&enable, select the first set bit searching upward from last-granted+1 with wrap. On the next edge go to ISSUE, load ch_sel, clear that pending bit, and update last-granted.
  - ISSUE: start=1 and busy=1 for exactly one cycle. Next state WAIT; counter cleared.
  - WAIT: busy=1, ch_sel held. Counter increments each cycle. On done=1 go to IDLE. If the counter reaches TO_MAX-1 with done=0, pulse timeout=1 for one cycle and go to IDLE.
- Pipelining: start rises one cycle after pending is first visible in IDLE. busy falls the cycle after done. A new grant cannot begin earlier than one IDLE cycle after WAIT ends.
- Simultaneous events:
  - Edge on the channel whose pending is being cleared in the same cycle: set wins, pending stays 1, and a second request is served later.
  - done in the same cycle as timeout expiry: done wins, no timeout pulse.
  - done in IDLE or ISSUE: ignored.
  - A second edge on an already-pending channel merges; there is no counting.
- Reset mid-operation: returns to IDLE in one edge with all outputs at reset values. In-flight and pending requests are discarded.
- ch_sel holds its last value in IDLE.
- Width: ch_sel is ceil(log2 NCH) wide. Out-of-range indices never occur.

Test Plan:
- SYNC=2, pulse sta_rt[2] high 5 cycles with enable=4'b1111 → pending[2] set 2 edges after first sample. start pulses 1 cycle later with ch_sel=2. busy holds until done; busy=0 the cycle after done.
- sta_rt=4'b1011 rising together, done returned 3 cycles after each start → grants in order 0,1,3. pending goes 1011→1010→1000→0000.
- Hold sta_rt[1] high 50 cycles → exactly one start for ch 1. Drop for 3 cycles, raise again → second start.
- TO_MAX=10, grant ch 0, never assert done → timeout pulses once, 10 cycles after entering WAIT. busy drops and ch 1 pending is granted next.
- Assert done on the exact timeout-expiry cycle → no timeout pulse, normal return to IDLE.
- Assert reset during WAIT with pending=4'b0110 → next cycle all outputs 0, pending=0. A fresh request on ch 3 is then granted normally with pointer restarted at ch 0.
